// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, FSM state type and byte/word helper functions.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} fsm_t;

   localparam logic [3:0] NR          = 4'd10;
   localparam int         BLOCK_BYTES = 16;
   localparam logic [3:0] LAST_BYTE   = 4'(BLOCK_BYTES - 1);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Table byte b sits at bits [2047-8b -: 8]; 255-b is simply ~b.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] get_byte(input logic [127:0] blk, input logic [3:0] i);
      return blk[{~i, 3'b111} -: 8];
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] s0, s1, s2, s3;
      s0 = col[31:24];
      s1 = col[23:16];
      s2 = col[15:8];
      s3 = col[7:0];
      return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
              s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
              s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
              xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
   endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES-128 round plus next round-key derivation.
module aes_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   input  logic         last,
   input  logic [7:0]   rcon,
   output logic [127:0] next_state,
   output logic [127:0] next_round_key
);

   logic [31:0]  w0, w1, w2, w3;
   logic [127:0] sb, sr, mc;

   always_comb begin
      w0 = round_key[127:96] ^ sub_word(rot_word(round_key[31:0])) ^ {rcon, 24'h000000};
      w1 = round_key[95:64] ^ w0;
      w2 = round_key[63:32] ^ w1;
      w3 = round_key[31:0]  ^ w2;
      next_round_key = {w0, w1, w2, w3};
   end

   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      for (int i = 0; i < 16; i++)
         sb[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
      // Row r of column c takes the byte from column (c+r) mod 4.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      for (int c = 0; c < 4; c++)
         mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
      next_state = (last ? sr : mc) ^ next_round_key;
   end

endmodule

// File: rtl/aes128_byte_serial_enc.sv
// rtl/aes128_byte_serial_enc.sv - byte-serial AES-128 encryptor; AES_STATUS_EN adds busy/round outputs.
module aes128_byte_serial_enc
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] data,
   input  logic [7:0] key,
   output logic [7:0] data_out,
   output logic       load,
   output logic       ready
`ifdef AES_STATUS_EN
   ,
   output logic       busy,
   output logic [3:0] round
`endif
);

   fsm_t         fsm, fsm_nxt;
   logic [3:0]   cnt;
   logic [3:0]   rnd;
   logic [127:0] data_reg, key_reg;
   logic [127:0] st, rk;
   logic [127:0] st_nxt, rk_nxt;

   aes_round u_round (
      .state          (st),
      .round_key      (rk),
      .last           (rnd == NR),
      .rcon           (rcon_of(rnd)),
      .next_state     (st_nxt),
      .next_round_key (rk_nxt)
   );

   always_comb begin
      fsm_nxt = fsm;
      load    = 1'b0;
      if (!enable) begin
         fsm_nxt = IDLE;
      end else begin
         case (fsm)
            IDLE: fsm_nxt = LOAD;
            LOAD: begin
               load = 1'b1;
               if (cnt == LAST_BYTE) fsm_nxt = RUN;
            end
            RUN:  if (rnd == NR) fsm_nxt = OUT;
            OUT:  if (cnt == 4'd0) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm      <= IDLE;
         cnt      <= 4'd0;
         rnd      <= 4'd0;
         data_reg <= '0;
         key_reg  <= '0;
         st       <= '0;
         rk       <= '0;
         data_out <= 8'h00;
         ready    <= 1'b0;
      end else begin
         fsm <= fsm_nxt;
         if (!enable) begin
            cnt   <= 4'd0;
            rnd   <= 4'd0;
            ready <= 1'b0;
         end else begin
            case (fsm)
               IDLE: begin
                  cnt   <= 4'd0;
                  rnd   <= 4'd0;
                  ready <= 1'b0;
               end
               LOAD: begin
                  data_reg[{~cnt, 3'b111} -: 8] <= data;
                  key_reg[{~cnt, 3'b111} -: 8]  <= key;
                  cnt <= cnt + 4'd1;
               end
               RUN: begin
                  if (rnd == 4'd0) begin
                     st <= data_reg ^ key_reg;
                     rk <= key_reg;
                  end else begin
                     st <= st_nxt;
                     rk <= rk_nxt;
                  end
                  // The final round also presents byte 0 so the first ready follows RUN directly.
                  if (rnd == NR) begin
                     data_out <= get_byte(st_nxt, 4'd0);
                     ready    <= 1'b1;
                     cnt      <= 4'd1;
                     rnd      <= 4'd0;
                  end else begin
                     rnd <= rnd + 4'd1;
                  end
               end
               OUT: begin
                  if (cnt == 4'd0) begin
                     ready <= 1'b0;
                  end else begin
                     data_out <= get_byte(st, cnt);
                     cnt      <= cnt + 4'd1;
                  end
               end
               default: ready <= 1'b0;
            endcase
         end
      end
   end

`ifdef AES_STATUS_EN
   assign busy  = (fsm != IDLE);
   assign round = (fsm == RUN) ? rnd : 4'd0;
`endif

endmodule

// File: tb/tb_aes128_byte_serial_enc.sv
// tb/tb_aes128_byte_serial_enc.sv - scoreboard bench for the byte-serial AES-128 encryptor.
module tb_aes128_byte_serial_enc;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic [7:0] data, key;
   logic [7:0] data_out;
   logic       load, ready;
`ifdef AES_STATUS_EN
   logic       busy;
   logic [3:0] round;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nbytes = 0;
   int first_cyc, last_load_cyc, first_load_cyc, ready_fall_cyc;
   logic         prev_ready = 1'b0;
   logic [127:0] got_blk;
   logic [127:0] exp_q[$];

   aes128_byte_serial_enc dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .data     (data),
      .key      (key),
      .data_out (data_out),
      .load     (load),
      .ready    (ready)
`ifdef AES_STATUS_EN
      ,
      .busy     (busy),
      .round    (round)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (nbytes == 0) begin
            first_cyc = cyc;
            check("latency", 128'(cyc - last_load_cyc), 128'd12);
         end
         got_blk = {got_blk[119:0], data_out};
         nbytes++;
         if (nbytes == 16) begin
            if (exp_q.size() == 0) check("unexpected_block", got_blk, 128'd0);
            else check("ciphertext", got_blk, exp_q.pop_front());
            nbytes = 0;
         end
      end else if (prev_ready === 1'b1) begin
         ready_fall_cyc = cyc;
         check("ready_run_len", 128'(nbytes), 128'd0);
`ifdef AES_STATUS_EN
         check("busy_drop", 128'(busy), 128'd0);
`endif
      end
      prev_ready = ready;
   end

   task automatic send_block(input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] ct, input bit push, input int abort_at);
      int i = 0;
      int guard = 0;
      bit aborted = 0;
      first_load_cyc = -1;
      while (i < 16 && guard < 300) begin
         @(negedge clk);
         guard++;
         if (!aborted && i == abort_at) begin
            enable = 1'b0;
            #1;
            check("abort_load", 128'(load), 128'd0);
            aborted = 1;
            i = 0;
         end else begin
            enable = 1'b1;
            data = pt[127-8*i -: 8];
            key  = k[127-8*i -: 8];
            #1;
            if (load) begin
               if (first_load_cyc < 0) first_load_cyc = cyc;
               if (i == 15) last_load_cyc = cyc;
               i++;
            end
         end
      end
      if (i < 16) check("load_timeout", 128'd0, 128'd1);
      else if (push) exp_q.push_back(ct);
   endtask

   task automatic wait_done();
      int guard = 0;
      while ((exp_q.size() != 0 || nbytes != 0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0 || nbytes != 0) check("done_timeout", 128'd0, 128'd1);
      enable = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; data = 8'h00; key = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_data_out", 128'(data_out), 128'd0);
      check("rst_load", 128'(load), 128'd0);
      check("rst_ready", 128'(ready), 128'd0);
`ifdef AES_STATUS_EN
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_round", 128'(round), 128'd0);
`endif
      reset = 1'b0;
      @(negedge clk);

      send_block(PT_B, KEY_B, CT_B, 1, -1);
      wait_done();

      send_block(PT_C, KEY_C, CT_C, 1, -1);
      wait_done();

      send_block(PT_B, KEY_B, CT_B, 1, -1);
      send_block(PT_C, KEY_C, CT_C, 1, -1);
      check("b2b_idle_gap", 128'(first_load_cyc - ready_fall_cyc), 128'd1);
      wait_done();

      send_block(PT_B, KEY_B, CT_B, 1, 7);
      wait_done();

      send_block(PT_C, KEY_C, CT_C, 0, -1);
      repeat (6) @(negedge clk);
`ifdef AES_STATUS_EN
      check("pre_rst_round", 128'(round), 128'd5);
`endif
      reset = 1'b1;
      @(negedge clk);
      check("midrun_data_out", 128'(data_out), 128'd0);
      check("midrun_load", 128'(load), 128'd0);
      check("midrun_ready", 128'(ready), 128'd0);
      reset = 1'b0;
      send_block(PT_B, KEY_B, CT_B, 1, -1);
      wait_done();

      send_block(128'd0, 128'd0, CT_Z, 1, -1);
`ifdef AES_STATUS_EN
      for (int r = 0; r <= 10; r++) begin
         @(negedge clk);
         check("round_step", 128'(round), 128'(r));
      end
`endif
      wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
